// File: rtl/serial_pkg.sv
// Shared types and constants for the 8051 mode-1 serial transmitter.
// Pure definitions; no logic, no latency.
package serial_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int DIV_SMOD0_DEF = 32;
    localparam int DIV_SMOD1_DEF = 16;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   FRAME_BITS = DATA_BITS_DEF + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_tick_div.sv
// Turns rising edges of Timer1 overflow into baud ticks and divides them by 16 or 32.
// bit_end is combinational in the cycle of the DIV-th tick; no backpressure.
module baud_tick_div
    import serial_pkg::*;
#(
    parameter int DIV_SMOD0 = DIV_SMOD0_DEF,
    parameter int DIV_SMOD1 = DIV_SMOD1_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tf1,
    input  logic clear,
    input  logic div_sel,
    output logic bit_end
);

    localparam int DIV_MAX = (DIV_SMOD0 > DIV_SMOD1) ? DIV_SMOD0 : DIV_SMOD1;
    localparam int CW      = cnt_width(DIV_MAX);
    localparam logic [CW-1:0] LAST0 = CW'(DIV_SMOD0 - 1);
    localparam logic [CW-1:0] LAST1 = CW'(DIV_SMOD1 - 1);

    logic          r_tf1_q;
    logic [CW-1:0] r_cnt;
    logic          w_tick;
    logic [CW-1:0] w_last;
    logic          w_wrap;

    // A held-high tf1 produces exactly one tick.
    assign w_tick  = tf1 & ~r_tf1_q;
    assign w_last  = div_sel ? LAST1 : LAST0;
    assign w_wrap  = w_tick && (r_cnt == w_last);
    assign bit_end = w_wrap & ~clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tf1_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_tf1_q <= tf1;
            if (clear || w_wrap) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_tx_mode1.sv
// 8051 SCON mode-1 transmitter: start bit, DATA_BITS LSB first, stop bit; TI raised at stop-bit start.
// txd falls one clk after an accepted write; writes while busy are silently dropped.
module serial_tx_mode1
    import serial_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int DIV_SMOD0 = DIV_SMOD0_DEF,
    parameter int DIV_SMOD1 = DIV_SMOD1_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tf1,
    input  logic                 smod,
    input  logic                 sbuf_wr,
    input  logic [DATA_BITS-1:0] sbuf_data,
    input  logic                 ti_clr,
    output logic                 txd,
    output logic                 ti,
    output logic                 busy
);

    localparam int BW = cnt_width(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    tx_state_e            r_state;
    tx_state_e            w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [BW-1:0]        r_bit_cnt;
    logic [BW-1:0]        w_bit_cnt_nxt;
    logic                 r_smod_q;
    logic                 r_ti;
    logic                 w_accept;
    logic                 w_ti_set;
    logic                 w_bit_end;

    baud_tick_div #(
        .DIV_SMOD0 (DIV_SMOD0),
        .DIV_SMOD1 (DIV_SMOD1)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .tf1     (tf1),
        .clear   (w_accept),
        .div_sel (r_smod_q),
        .bit_end (w_bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_smod_q  <= 1'b0;
            r_ti      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            if (w_accept) begin
                r_smod_q <= smod;
            end
            // A set in the same cycle as a software clear wins.
            if (w_ti_set) begin
                r_ti <= 1'b1;
            end else if (ti_clr) begin
                r_ti <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_accept      = 1'b0;
        w_ti_set      = 1'b0;
        txd           = STOP_BIT;
        case (r_state)
            IDLE: begin
                if (sbuf_wr) begin
                    w_accept    = 1'b1;
                    w_shift_nxt = sbuf_data;
                    w_state_nxt = START;
                end
            end
            START: begin
                txd = START_BIT;
                if (w_bit_end) begin
                    w_state_nxt   = DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                txd = r_shift[0];
                if (w_bit_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = STOP;
                        w_ti_set    = 1'b1;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign ti   = r_ti;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_serial_tx_mode1.sv
// Randomized bench: a tick-level frame model predicts txd/busy/ti every cycle and a scoreboard checks decoded frames.
module tb_serial_tx_mode1;

    localparam int DIV0 = 32;
    localparam int DIV1 = 16;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       tf1       = 1'b0;
    logic       smod      = 1'b0;
    logic       sbuf_wr   = 1'b0;
    logic [7:0] sbuf_data = 8'h00;
    logic       ti_clr    = 1'b0;
    logic       txd;
    logic       ti;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int tf1_mode = 3;   // 0: 1-clk pulse every 4 clk, 1: held high, 2: low, 3: random
    int cyc = 0;

    typedef struct {
        logic [7:0] data;
        logic       smod;
    } frame_t;
    frame_t exp_q[$];

    // Reference model state, expressed in ticks since frame acceptance.
    logic       m_busy     = 1'b0;
    logic       m_ti       = 1'b0;
    logic       m_tf1_prev = 1'b0;
    int         m_c        = 0;
    int         m_div      = DIV1;
    logic [7:0] m_byte     = 8'h00;
    logic [9:0] rx_bits    = '0;
    logic       samp_pend  = 1'b0;
    int         samp_idx   = 0;

    serial_tx_mode1 #(
        .DATA_BITS (8),
        .DIV_SMOD0 (DIV0),
        .DIV_SMOD1 (DIV1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tf1       (tf1),
        .smod      (smod),
        .sbuf_wr   (sbuf_wr),
        .sbuf_data (sbuf_data),
        .ti_clr    (ti_clr),
        .txd       (txd),
        .ti        (ti),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        int b;
        if (!m_busy) return 1'b1;
        b = m_c / m_div;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    task automatic model_step();
        logic   tick;
        logic   set;
        frame_t f;
        tick       = tf1 & ~m_tf1_prev;
        m_tf1_prev = tf1;
        set        = 1'b0;
        if (!m_busy) begin
            if (sbuf_wr) begin
                m_busy = 1'b1;
                m_c    = 0;
                m_div  = smod ? DIV1 : DIV0;
                m_byte = sbuf_data;
            end
        end else if (tick) begin
            m_c++;
            if (m_c % m_div == m_div / 2) begin
                samp_pend = 1'b1;
                samp_idx  = m_c / m_div;
            end
            if (m_c == 9 * m_div) set = 1'b1;
            if (m_c == 10 * m_div) begin
                m_busy = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_sb: got frame %02h expected no frame at %0t", rx_bits[8:1], $time);
                end else begin
                    f = exp_q.pop_front();
                    check8("frame_data", rx_bits[8:1], f.data);
                    check1("frame_start", rx_bits[0], 1'b0);
                    check1("frame_stop", rx_bits[9], 1'b1);
                end
            end
        end
        if (set) m_ti = 1'b1;
        else if (ti_clr) m_ti = 1'b0;
    endtask

    // Monitor: compare against the model, then advance the model with this cycle's inputs.
    initial forever begin
        frame_t drop;
        @(negedge clk);
        if (!rst) begin
            check1("rst_txd", txd, 1'b1);
            check1("rst_ti", ti, 1'b0);
            check1("rst_busy", busy, 1'b0);
            if (m_busy && exp_q.size() > 0) drop = exp_q.pop_front();
            m_busy     = 1'b0;
            m_ti       = 1'b0;
            m_tf1_prev = 1'b0;
            m_c        = 0;
            samp_pend  = 1'b0;
        end else begin
            check1("txd", txd, exp_txd());
            check1("busy", busy, m_busy);
            check1("ti", ti, m_ti);
            if (samp_pend) begin
                rx_bits[samp_idx] = txd;
                samp_pend = 1'b0;
            end
            model_step();
        end
    end

    // Timer1 overflow source.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        case (tf1_mode)
            0:       tf1 = (cyc % 4 == 0);
            1:       tf1 = 1'b1;
            2:       tf1 = 1'b0;
            default: tf1 = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic write(input logic [7:0] d, input logic s);
        @(posedge clk);
        #2;
        sbuf_data = d;
        smod      = s;
        sbuf_wr   = 1'b1;
        if (!m_busy) exp_q.push_back('{data: d, smod: s});
        @(posedge clk);
        #2;
        sbuf_wr   = 1'b0;
        sbuf_data = 8'($urandom);
    endtask

    task automatic pulse_ti_clr();
        @(posedge clk);
        #2;
        ti_clr = 1'b1;
        @(posedge clk);
        #2;
        ti_clr = 1'b0;
    endtask

    // Waits for frame end while wiggling smod and occasionally clearing TI.
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            smod   = 1'($urandom_range(0, 1));
            ti_clr = ($urandom_range(0, 99) == 0);
            n++;
        end while (m_busy && n < 6000);
        ti_clr = 1'b0;
        if (m_busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic wait_count(input int target);
        int n;
        n = 0;
        while (!(m_busy && m_c >= target) && n < 6000) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    // Returns in the cycle whose tick will land the model at m_c == target.
    task automatic wait_tick_to(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!(m_busy && m_c == target - 1 && tf1 && !m_tf1_prev) && n < 6000);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #2;
            sbuf_wr   = 1'($urandom_range(0, 1));
            sbuf_data = 8'($urandom);
            smod      = 1'($urandom_range(0, 1));
            ti_clr    = 1'($urandom_range(0, 1));
        end
        sbuf_wr = 1'b0;
        ti_clr  = 1'b0;
        tf1_mode = 2;
        cyc_wait(2);
        rst = 1'b1;
        tf1_mode = 0;
        cyc_wait(3);

        // Basic frame, smod=1.
        write(8'hA5, 1'b1);
        @(negedge clk);
        check1("start_after_strobe", txd, 1'b0);
        wait_idle();

        // smod=0, smod toggled during the frame by wait_idle.
        write(8'h3C, 1'b0);
        wait_idle();

        // Write while busy is dropped.
        write(8'hFF, 1'b1);
        cyc_wait(100);
        write(8'h55, 1'b0);
        wait_idle();

        // Write in the STOP->IDLE cycle is dropped.
        write(8'h0F, 1'b1);
        wait_tick_to(10 * DIV1);
        sbuf_wr   = 1'b1;
        sbuf_data = 8'h77;
        @(posedge clk);
        #2;
        sbuf_wr = 1'b0;
        cyc_wait(3);
        @(negedge clk);
        check1("collision_ignored", busy, 1'b0);
        write(8'h5A, 1'b1);
        wait_idle();

        // TI set coincides with ti_clr.
        pulse_ti_clr();
        write(8'h99, 1'b1);
        wait_tick_to(9 * DIV1);
        ti_clr = 1'b1;
        @(posedge clk);
        #2;
        ti_clr = 1'b0;
        @(negedge clk);
        check1("ti_set_wins", ti, 1'b1);
        cyc_wait(20);
        pulse_ti_clr();
        @(negedge clk);
        check1("ti_later_clr", ti, 1'b0);
        wait_idle();

        // Reset in the middle of data bit 4 of 0x00.
        pulse_ti_clr();
        write(8'h00, 1'b1);
        wait_count(5 * DIV1 + 5);
        rst = 1'b0;
        #1;
        check1("abort_txd", txd, 1'b1);
        check1("abort_busy", busy, 1'b0);
        check1("abort_ti", ti, 1'b0);
        cyc_wait(3);
        rst = 1'b1;
        cyc_wait(2);
        write(8'h81, 1'b1);
        wait_idle();

        // tf1 held high for 50 clk counts as one tick.
        write(8'hC3, 1'b1);
        wait_count(20);
        tf1_mode = 1;
        cyc_wait(50);
        tf1_mode = 0;
        wait_idle();

        // Random frames with occasional writes during the frame.
        for (int i = 0; i < 4; i++) begin
            write(8'($urandom), 1'($urandom_range(0, 1)));
            cyc_wait($urandom_range(0, 200));
            write(8'($urandom), 1'($urandom_range(0, 1)));
            wait_idle();
        end

        cyc_wait(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
